// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX-stage divide handshake.
// Returns {remainder, quotient}; one divide in flight, operands captured at acceptance.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  logic [1:0]          state_r;
  logic [5:0]          cnt_r;
  logic [DATA_W-1:0]   dvd_r;
  logic [DATA_W-1:0]   dvs_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   quo_r;
  logic                neg_q_r;
  logic                neg_rem_r;
  logic [2*DATA_W-1:0] res_r;

  logic [DATA_W-1:0]   abs1_s;
  logic [DATA_W-1:0]   abs2_s;
  logic [DATA_W:0]     shift_s;
  logic [DATA_W:0]     diff_s;
  logic                fits_s;
  logic [DATA_W-1:0]   rem_nxt_s;
  logic [DATA_W-1:0]   quo_nxt_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // Operand magnitudes, one restoring step, and the sign fix for the final step
  always_comb begin
    abs1_s    = opdata1_i;
    abs2_s    = opdata2_i;
    shift_s   = {rem_r, dvd_r[DATA_W-1]};
    diff_s    = shift_s - {1'b0, dvs_r};
    fits_s    = ~diff_s[DATA_W];
    rem_nxt_s = shift_s[DATA_W-1:0];
    quo_nxt_s = {quo_r[DATA_W-2:0], fits_s};
    quo_fix_s = quo_nxt_s;
    rem_fix_s = rem_nxt_s;
    if (signed_div_i && opdata1_i[DATA_W-1]) begin
      abs1_s = -opdata1_i;
    end else begin
      abs1_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[DATA_W-1]) begin
      abs2_s = -opdata2_i;
    end else begin
      abs2_s = opdata2_i;
    end
    // A remainder below the divisor always fits the low bits of the difference
    if (fits_s) begin
      rem_nxt_s = diff_s[DATA_W-1:0];
    end else begin
      rem_nxt_s = shift_s[DATA_W-1:0];
    end
    if (neg_q_r) begin
      quo_fix_s = -quo_nxt_s;
    end else begin
      quo_fix_s = quo_nxt_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = -rem_nxt_s;
    end else begin
      rem_fix_s = rem_nxt_s;
    end
  end

  // Divider FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FREE;
      cnt_r     <= 6'd0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      res_r     <= '0;
      ready_o   <= 1'b0;
      result_o  <= '0;
    end else begin
      case (state_r)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            dvd_r     <= abs1_s;
            dvs_r     <= abs2_s;
            neg_q_r   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_r <= signed_div_i & opdata1_i[DATA_W-1];
            cnt_r     <= 6'd0;
            rem_r     <= '0;
            quo_r     <= '0;
            if (opdata2_i == '0) begin
              state_r <= ST_BYZERO;
            end else begin
              state_r <= ST_ON;
            end
          end else begin
            state_r <= ST_FREE;
          end
        end
        ST_BYZERO: begin
          if (annul_i) begin
            state_r <= ST_FREE;
          end else begin
            res_r   <= '0;
            state_r <= ST_END;
          end
        end
        ST_ON: begin
          if (annul_i) begin
            state_r <= ST_FREE;
          end else begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            dvd_r <= {dvd_r[DATA_W-2:0], 1'b0};
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == LAST_ITER) begin
              res_r   <= {rem_fix_s, quo_fix_s};
              state_r <= ST_END;
            end else begin
              state_r <= ST_ON;
            end
          end
        end
        ST_END: begin
          if (annul_i || !start_i) begin
            state_r  <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            state_r  <= ST_END;
            ready_o  <= 1'b1;
            result_o <= res_r;
          end
        end
        default: begin
          state_r  <= ST_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
